// File: rtl/simple_phase_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the SIMPLE 16-bit core.
// Decodes the latched IR into ALU, register-file, memory and PC controls.
module simple_phase_sequencer #(
    parameter int DATA_W        = 16,
    parameter int REG_AW        = 3,
    parameter int HALT_ON_UNDEF = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_run,
    input  logic [15:0]       i_instr,
    input  logic              i_instr_ack,
    input  logic [3:0]        i_szcv,
    input  logic              i_mem_ack,
    output logic              o_fetch_req,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [3:0]        o_alu_op,
    output logic              o_alu_b_imm,
    output logic [DATA_W-1:0] o_imm,
    output logic [REG_AW-1:0] o_ra_addr,
    output logic [REG_AW-1:0] o_rb_addr,
    output logic              o_reg_we,
    output logic [REG_AW-1:0] o_reg_waddr,
    output logic [1:0]        o_wb_sel,
    output logic              o_flags_we,
    output logic              o_out_we,
    output logic              o_pc_inc,
    output logic              o_pc_load,
    output logic              o_halted,
    output logic [4:0]        o_phase
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t      r_state;
    logic [15:0] r_ir;

    logic [1:0] w_op1;
    logic [2:0] w_op2;
    logic [2:0] w_cc;
    logic [3:0] w_op3;
    logic w_alu, w_ld, w_st, w_li, w_b, w_bc;
    logic w_arith, w_cmp, w_shift, w_in, w_out, w_hlt;
    logic w_undef, w_wr, w_flags, w_taken;
    logic w_s, w_z, w_v;
    logic w_unused_c;
    logic [DATA_W-1:0] w_imm;
    logic [REG_AW-1:0] w_waddr;
    logic [1:0]        w_wbsel;

    assign w_op1 = r_ir[15:14];
    assign w_op2 = r_ir[13:11];
    assign w_cc  = r_ir[10:8];
    assign w_op3 = r_ir[7:4];

    assign w_alu   = (w_op1 == 2'b11);
    assign w_ld    = (w_op1 == 2'b00);
    assign w_st    = (w_op1 == 2'b01);
    assign w_li    = (w_op1 == 2'b10) && (w_op2 == 3'b000);
    assign w_b     = (w_op1 == 2'b10) && (w_op2 == 3'b100);
    assign w_bc    = (w_op1 == 2'b10) && (w_op2 == 3'b111) && !w_cc[2];
    assign w_arith = w_alu && (w_op3 <= 4'd6);
    assign w_cmp   = w_alu && (w_op3 == 4'd5);
    assign w_shift = w_alu && (w_op3[3:2] == 2'b10);
    assign w_in    = w_alu && (w_op3 == 4'hC);
    assign w_out   = w_alu && (w_op3 == 4'hD);
    assign w_hlt   = w_alu && (w_op3 == 4'hF);

    assign w_undef = !(w_ld || w_st || w_li || w_b || w_bc || w_arith
                       || w_shift || w_in || w_out || w_hlt);
    assign w_wr    = (w_arith && !w_cmp) || w_shift || w_in || w_li || w_ld;
    assign w_flags = w_arith || w_shift;

    assign w_s        = i_szcv[3];
    assign w_z        = i_szcv[2];
    assign w_v        = i_szcv[0];
    assign w_unused_c = i_szcv[1];

    always_comb begin
        w_taken = w_b;
        if (w_bc) begin
            unique case (w_cc[1:0])
                2'b00: w_taken = w_z;
                2'b01: w_taken = w_s ^ w_v;
                2'b10: w_taken = w_z | (w_s ^ w_v);
                2'b11: w_taken = !w_z;
                default: w_taken = 1'b0;
            endcase
        end
    end

    // Branch and memory offsets are signed; shift amounts are not.
    always_comb begin
        w_imm = '0;
        if (w_ld || w_st || w_li || w_b || w_bc)
            w_imm = DATA_W'($signed(r_ir[7:0]));
        else if (w_shift)
            w_imm = DATA_W'(r_ir[3:0]);
    end

    always_comb begin
        w_waddr = REG_AW'(r_ir[10:8]);
        w_wbsel = 2'b00;
        if (w_ld) begin
            w_waddr = REG_AW'(r_ir[13:11]);
            w_wbsel = 2'b01;
        end else if (w_li) begin
            w_wbsel = 2'b10;
        end else if (w_in) begin
            w_wbsel = 2'b11;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_FETCH;
            r_ir    <= '0;
        end else begin
            unique case (r_state)
                S_FETCH: begin
                    if (i_instr_ack) begin
                        r_ir    <= i_instr;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (w_hlt || (w_undef && HALT_ON_UNDEF != 0))
                        r_state <= S_HALT;
                    else
                        r_state <= S_EXEC;
                end
                S_EXEC:
                    r_state <= (w_ld || w_st) ? S_MEM : S_WB;
                S_MEM: begin
                    if (i_mem_ack)
                        r_state <= w_st ? S_FETCH : S_WB;
                end
                S_WB:
                    r_state <= S_FETCH;
                S_HALT: begin
                    if (i_run)
                        r_state <= S_FETCH;
                end
                default:
                    r_state <= S_FETCH;
            endcase
        end
    end

    // Reset forces every output quiet in the same cycle, even mid-handshake.
    always_comb begin
        o_fetch_req = 1'b0;
        o_mem_req   = 1'b0;
        o_mem_we    = 1'b0;
        o_alu_op    = 4'd0;
        o_alu_b_imm = 1'b0;
        o_imm       = '0;
        o_ra_addr   = '0;
        o_rb_addr   = '0;
        o_reg_we    = 1'b0;
        o_reg_waddr = '0;
        o_wb_sel    = 2'b00;
        o_flags_we  = 1'b0;
        o_out_we    = 1'b0;
        o_pc_inc    = 1'b0;
        o_pc_load   = 1'b0;
        o_halted    = 1'b0;
        o_phase     = 5'b00001;
        if (!i_rst) begin
            o_alu_op    = w_alu ? w_op3 : 4'd0;
            o_alu_b_imm = w_ld || w_st || w_shift;
            o_imm       = w_imm;
            o_ra_addr   = REG_AW'(r_ir[13:11]);
            o_rb_addr   = REG_AW'(r_ir[10:8]);
            o_phase     = 5'b00000;
            unique case (r_state)
                S_FETCH: begin
                    o_phase     = 5'b00001;
                    o_fetch_req = 1'b1;
                    o_pc_inc    = i_instr_ack;
                end
                S_DECODE:
                    o_phase = 5'b00010;
                S_EXEC: begin
                    o_phase    = 5'b00100;
                    o_flags_we = w_flags;
                    o_pc_load  = w_taken;
                end
                S_MEM: begin
                    o_phase   = 5'b01000;
                    o_mem_req = 1'b1;
                    o_mem_we  = w_st;
                end
                S_WB: begin
                    o_phase     = 5'b10000;
                    o_reg_we    = w_wr;
                    o_reg_waddr = w_waddr;
                    o_wb_sel    = w_wbsel;
                    o_out_we    = w_out;
                end
                S_HALT:
                    o_halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_simple_phase_sequencer.sv
// Directed bench for simple_phase_sequencer: per-instruction vector table
// plus hand-written memory, halt, fetch-wait and reset sequences.
module tb_simple_phase_sequencer;

    logic        clk = 1'b0;
    logic        rst, run, iack, mack;
    logic [15:0] instr;
    logic [3:0]  szcv;

    logic        f_req, m_req, m_we, bimm, rwe, fwe, owe, pinc, pld, hlt;
    logic [3:0]  aop;
    logic [15:0] imm;
    logic [2:0]  ra, rb, wa;
    logic [1:0]  ws;
    logic [4:0]  ph;

    logic        u1_freq, u1_mreq, u1_mwe, u1_bimm, u1_rwe, u1_fwe;
    logic        u1_owe, u1_pinc, u1_pld, u1_hlt;
    logic [3:0]  u1_aop;
    logic [15:0] u1_imm;
    logic [2:0]  u1_ra, u1_rb, u1_wa;
    logic [1:0]  u1_ws;
    logic [4:0]  u1_ph;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    simple_phase_sequencer #(.DATA_W(16), .REG_AW(3), .HALT_ON_UNDEF(1)) u0 (
        .i_clk(clk), .i_rst(rst), .i_run(run), .i_instr(instr),
        .i_instr_ack(iack), .i_szcv(szcv), .i_mem_ack(mack),
        .o_fetch_req(f_req), .o_mem_req(m_req), .o_mem_we(m_we),
        .o_alu_op(aop), .o_alu_b_imm(bimm), .o_imm(imm),
        .o_ra_addr(ra), .o_rb_addr(rb), .o_reg_we(rwe),
        .o_reg_waddr(wa), .o_wb_sel(ws), .o_flags_we(fwe),
        .o_out_we(owe), .o_pc_inc(pinc), .o_pc_load(pld),
        .o_halted(hlt), .o_phase(ph)
    );

    simple_phase_sequencer #(.DATA_W(16), .REG_AW(3), .HALT_ON_UNDEF(0)) u1 (
        .i_clk(clk), .i_rst(rst), .i_run(run), .i_instr(instr),
        .i_instr_ack(iack), .i_szcv(szcv), .i_mem_ack(mack),
        .o_fetch_req(u1_freq), .o_mem_req(u1_mreq), .o_mem_we(u1_mwe),
        .o_alu_op(u1_aop), .o_alu_b_imm(u1_bimm), .o_imm(u1_imm),
        .o_ra_addr(u1_ra), .o_rb_addr(u1_rb), .o_reg_we(u1_rwe),
        .o_reg_waddr(u1_wa), .o_wb_sel(u1_ws), .o_flags_we(u1_fwe),
        .o_out_we(u1_owe), .o_pc_inc(u1_pinc), .o_pc_load(u1_pld),
        .o_halted(u1_hlt), .o_phase(u1_ph)
    );

    typedef struct {
        string nm;
        int ir, szcv, ra, rb, aop, bimm, ci, imm;
        int fwe, pld, rwe, wa, ws, owe, hlt;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [45:0] all_out();
        return {f_req, m_req, m_we, aop, bimm, imm, ra, rb, rwe,
                wa, ws, fwe, owe, pinc, pld, hlt, ph};
    endfunction

    function automatic logic [7:0] strobes();
        return {f_req, m_req, m_we, rwe, fwe, owe, pinc, pld};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    // Fetch with immediate ack, then step through DECODE and EXEC.
    task automatic to_mem(input logic [15:0] w);
        instr = w;
        iack = 1'b1;
        cyc();
        iack = 1'b0;
        cyc();
        cyc();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        int n;
        tv.push_back('{"add",   'hCA00, 0, 1, 2, 0, 0, 0, 0, 1, 0, 1, 2, 0, 0, 0});
        tv.push_back('{"sub",   'hDC10, 0, 3, 4, 1, 0, 0, 0, 1, 0, 1, 4, 0, 0, 0});
        tv.push_back('{"cmp",   'hCA50, 0, 1, 2, 5, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0});
        tv.push_back('{"mov",   'hCE60, 0, 1, 6, 6, 0, 0, 0, 1, 0, 1, 6, 0, 0, 0});
        tv.push_back('{"sra",   'hC5BF, 0, 0, 5, 11, 1, 1, 'h000F, 1, 0, 1, 5, 0, 0, 0});
        tv.push_back('{"in",    'hC6C0, 0, 0, 6, 12, 0, 0, 0, 0, 0, 1, 6, 3, 0, 0});
        tv.push_back('{"out",   'hC8D0, 0, 1, 0, 13, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0});
        tv.push_back('{"li",    'h8280, 0, 0, 2, 0, 0, 1, 'hFF80, 0, 0, 1, 2, 2, 0, 0});
        tv.push_back('{"be_t",  'hB805, 4, 7, 0, 0, 0, 1, 'h0005, 0, 1, 0, 0, 0, 0, 0});
        tv.push_back('{"be_n",  'hB805, 0, 7, 0, 0, 0, 1, 'h0005, 0, 0, 0, 0, 0, 0, 0});
        tv.push_back('{"b",     'hA0FF, 0, 4, 0, 0, 0, 1, 'hFFFF, 0, 1, 0, 0, 0, 0, 0});
        tv.push_back('{"blt_t", 'hB903, 8, 7, 1, 0, 0, 1, 'h0003, 0, 1, 0, 0, 0, 0, 0});
        tv.push_back('{"blt_n", 'hB903, 9, 7, 1, 0, 0, 1, 'h0003, 0, 0, 0, 0, 0, 0, 0});
        tv.push_back('{"ble_n", 'hBA02, 2, 7, 2, 0, 0, 1, 'h0002, 0, 0, 0, 0, 0, 0, 0});
        tv.push_back('{"ble_z", 'hBA02, 4, 7, 2, 0, 0, 1, 'h0002, 0, 1, 0, 0, 0, 0, 0});
        tv.push_back('{"ble_v", 'hBA02, 1, 7, 2, 0, 0, 1, 'h0002, 0, 1, 0, 0, 0, 0, 0});
        tv.push_back('{"bne_t", 'hBB07, 0, 7, 3, 0, 0, 1, 'h0007, 0, 1, 0, 0, 0, 0, 0});
        tv.push_back('{"bne_n", 'hBB07, 4, 7, 3, 0, 0, 1, 'h0007, 0, 0, 0, 0, 0, 0, 0});
        tv.push_back('{"hlt",   'hC0F0, 0, 0, 0, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1});
        tv.push_back('{"und",   'hC070, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1});

        rst = 1'b1; run = 1'b0; iack = 1'b0; mack = 1'b0;
        instr = 16'h0; szcv = 4'h0;
        #1;
        chk("rst_pre_edge", all_out(), 46'h1);
        cyc();
        chk("rst_held", all_out(), 46'h1);
        cyc();
        rst = 1'b0;
        #1;

        foreach (tv[i]) begin
            v = tv[i];
            instr = 16'(v.ir);
            szcv = 4'(v.szcv);
            iack = 1'b1;
            #1;
            chk({v.nm, ".fph"}, ph, 5'b00001);
            chk({v.nm, ".freq"}, f_req, 1);
            chk({v.nm, ".pinc"}, pinc, 1);
            cyc();
            iack = 1'b0;
            #1;
            chk({v.nm, ".dph"}, ph, 5'b00010);
            chk({v.nm, ".ra"}, ra, v.ra);
            chk({v.nm, ".rb"}, rb, v.rb);
            chk({v.nm, ".dstb"}, strobes(), 0);
            cyc();
            if (v.hlt != 0) begin
                chk({v.nm, ".halted"}, hlt, 1);
                chk({v.nm, ".hph"}, ph, 5'b00000);
                run = 1'b1;
                cyc();
                run = 1'b0;
                chk({v.nm, ".refetch"}, f_req, 1);
                continue;
            end
            chk({v.nm, ".eph"}, ph, 5'b00100);
            chk({v.nm, ".fwe"}, fwe, v.fwe);
            chk({v.nm, ".pld"}, pld, v.pld);
            chk({v.nm, ".aop"}, aop, v.aop);
            chk({v.nm, ".bimm"}, bimm, v.bimm);
            if (v.ci != 0)
                chk({v.nm, ".imm"}, imm, v.imm);
            chk({v.nm, ".erwe"}, rwe, 0);
            cyc();
            chk({v.nm, ".wph"}, ph, 5'b10000);
            chk({v.nm, ".rwe"}, rwe, v.rwe);
            if (v.rwe != 0) begin
                chk({v.nm, ".wa"}, wa, v.wa);
                chk({v.nm, ".ws"}, ws, v.ws);
            end
            chk({v.nm, ".owe"}, owe, v.owe);
            chk({v.nm, ".wfwe"}, fwe, 0);
            chk({v.nm, ".wpld"}, pld, 0);
            cyc();
        end

        do_reset();
        #1;
        // Fetch stall, then LD r3,-2(r1) with mem_ack on the fourth MEM cycle.
        for (int k = 0; k < 2; k++) begin
            chk("fwait.freq", f_req, 1);
            chk("fwait.pinc", pinc, 0);
            cyc();
        end
        instr = 16'h19FE;
        iack = 1'b1;
        #1;
        chk("ld.pinc", pinc, 1);
        cyc();
        iack = 1'b0;
        chk("ld.ra", ra, 3);
        chk("ld.rb", rb, 1);
        cyc();
        chk("ld.imm", imm, 16'hFFFE);
        chk("ld.bimm", bimm, 1);
        chk("ld.aop", aop, 0);
        chk("ld.fwe", fwe, 0);
        cyc();
        n = 0;
        for (int k = 0; k < 4; k++) begin
            mack = (k == 3);
            #1;
            if (m_req) n++;
            chk("ld.mph", ph, 5'b01000);
            chk("ld.mwe", m_we, 0);
            cyc();
        end
        mack = 1'b0;
        chk("ld.req_cycles", n, 4);
        chk("ld.wph", ph, 5'b10000);
        chk("ld.mreq_off", m_req, 0);
        chk("ld.rwe", rwe, 1);
        chk("ld.wa", wa, 3);
        chk("ld.ws", ws, 1);
        cyc();

        // ST r2,4(r5): one wait, then straight back to FETCH.
        to_mem(16'h5504);
        chk("st.mreq", m_req, 1);
        chk("st.mwe", m_we, 1);
        chk("st.imm", imm, 16'h0004);
        cyc();
        mack = 1'b1;
        #1;
        chk("st.mwe_hold", {m_req, m_we}, 2'b11);
        cyc();
        mack = 1'b0;
        chk("st.back_fetch", ph, 5'b00001);
        chk("st.rwe", rwe, 0);

        // HLT: quiet for 10 cycles, run pulse restarts fetching.
        to_mem(16'hC0F0);
        for (int k = 0; k < 10; k++) begin
            chk("hlt.halted", hlt, 1);
            chk("hlt.strobes", strobes(), 0);
            cyc();
        end
        run = 1'b1;
        cyc();
        run = 1'b0;
        chk("hlt.run_fetch", f_req, 1);
        chk("hlt.run_unhalt", hlt, 0);

        // Reset while waiting in MEM.
        to_mem(16'h19FE);
        cyc();
        chk("rmem.waiting", m_req, 1);
        rst = 1'b1;
        cyc();
        chk("rmem.all_out", all_out(), 46'h1);
        rst = 1'b0;
        #1;
        chk("rmem.refetch", f_req, 1);
        chk("rmem.mreq", m_req, 0);

        // Undefined opcode with HALT_ON_UNDEF=0 is a NOP.
        do_reset();
        instr = 16'hC070;
        iack = 1'b1;
        cyc();
        iack = 1'b0;
        chk("nop.dph", u1_ph, 5'b00010);
        cyc();
        chk("nop.eph", u1_ph, 5'b00100);
        chk("nop.efwe", u1_fwe, 0);
        chk("u0.und_halt", hlt, 1);
        cyc();
        chk("nop.wph", u1_ph, 5'b10000);
        chk("nop.rwe", u1_rwe, 0);
        chk("nop.fwe", u1_fwe, 0);
        cyc();
        chk("nop.fetch", u1_ph, 5'b00001);
        chk("nop.halted", u1_hlt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
